// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target engine.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;

    localparam logic [6:0] I2C_DEFAULT_ADDRESS = 7'h2f;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus a run-length glitch filter for one I2C line.
// The filtered level only moves after FILTER_LEN consecutive samples that
// disagree with it; rise_o/fall_o pulse in the first cycle of the new level.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       filt_q;
    logic       rise_q;
    logic       fall_q;
    logic [3:0] cnt_q;

    // Synchronize, then count disagreeing samples until the run is long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                filt_q <= sync2_q;
                rise_q <= sync2_q;
                fall_q <= ~sync2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign line_o = filt_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target.sv
// Byte-level I2C target for the bootloader command port.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_IDLE      | not addressed, SDA released
//   ST_ADDR      | shifting in address + R/W after START/Sr
//   ST_ADDR_ACK  | driving ACK for a matched address
//   ST_WR_BYTE   | shifting in a data byte from the master
//   ST_WR_ACK    | driving ACK for a received data byte
//   ST_RD_BYTE   | driving a response byte MSB-first
//   ST_RD_ACK    | SDA released, sampling master ACK/NACK
//   ST_WAIT_STOP | master NACKed; idle until STOP or Sr
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  ADDRESS    = I2C_DEFAULT_ADDRESS,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       start,
    output logic       stop,
    output logic       read_mode,
    input  logic [7:0] tx_data,
    output logic       tx_pop
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk    (clk),
        .rst    (rst),
        .line_i (i2c_scl),
        .line_o (scl_f),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk    (clk),
        .rst    (rst),
        .line_i (i2c_sda_in),
        .line_o (sda_f),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    logic bus_start;
    logic bus_stop;
    assign bus_start = sda_fall & scl_f;
    assign bus_stop  = sda_rise & scl_f;

    i2c_state_e state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic       phase_q;      // ACK slots: second half pending / master ACKed
    logic       addressed_q;
    logic       read_mode_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       start_q;
    logic       stop_q;
    logic       tx_pop_q;
    logic       sda_oe_q;

    assign shift_d = {shift_q[6:0], sda_f};

    // Protocol FSM; bus conditions take priority over any SCL edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            phase_q     <= 1'b0;
            addressed_q <= 1'b0;
            read_mode_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            tx_pop_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            tx_pop_q   <= 1'b0;
            if (bus_stop) begin
                stop_q      <= addressed_q;
                addressed_q <= 1'b0;
                read_mode_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                state_q     <= ST_IDLE;
            end else if (bus_start) begin
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                state_q   <= ST_ADDR;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (shift_d[7:1] == ADDRESS) begin
                                    start_q     <= 1'b1;
                                    addressed_q <= 1'b1;
                                    read_mode_q <= shift_d[0];
                                    phase_q     <= 1'b0;
                                    state_q     <= ST_ADDR_ACK;
                                end else begin
                                    addressed_q <= 1'b0;
                                    read_mode_q <= 1'b0;
                                    state_q     <= ST_IDLE;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_oe_q <= 1'b1;
                                phase_q  <= 1'b1;
                            end else begin
                                bit_cnt_q <= '0;
                                if (state_q == ST_ADDR_ACK && read_mode_q == I2C_READ) begin
                                    tx_pop_q <= 1'b1;
                                    shift_q  <= tx_data;
                                    sda_oe_q <= ~tx_data[7];
                                    state_q  <= ST_RD_BYTE;
                                end else begin
                                    sda_oe_q <= 1'b0;
                                    state_q  <= ST_WR_BYTE;
                                end
                            end
                        end
                    end
                    ST_WR_BYTE: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_q  <= shift_d;
                                rx_valid_q <= 1'b1;
                                phase_q    <= 1'b0;
                                state_q    <= ST_WR_ACK;
                            end
                        end
                    end
                    ST_RD_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 3'd7) begin
                                sda_oe_q <= 1'b0;
                                phase_q  <= 1'b0;
                                state_q  <= ST_RD_ACK;
                            end else begin
                                shift_q   <= {shift_q[6:0], 1'b0};
                                sda_oe_q  <= ~shift_q[6];
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                state_q <= ST_WAIT_STOP;
                            end else begin
                                phase_q <= 1'b1;
                            end
                        end else if (scl_fall && phase_q) begin
                            tx_pop_q  <= 1'b1;
                            shift_q   <= tx_data;
                            sda_oe_q  <= ~tx_data[7];
                            bit_cnt_q <= '0;
                            state_q   <= ST_RD_BYTE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign i2c_sda_oe = sda_oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign start      = start_q;
    assign stop       = stop_q;
    assign read_mode  = read_mode_q;
    assign tx_pop     = tx_pop_q;

endmodule
